// File: rtl/mux_nbit_pipe.sv
// mux_nbit_pipe: N-input, WIDTH-bit multiplexer with a registered,
// valid/ready flow-controlled output held in a 2-entry skid buffer.
// The head register drives the outputs. The skid register absorbs the one
// extra word that can arrive in the cycle where downstream stalls.
// Select codes at or above NUM_INPUTS capture DEFAULT_DATA and set a
// sticky error flag.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | no word held; out_valid=0, in_ready=1
// S_ONE   | head holds a word; out_valid=1, in_ready=1
// S_TWO   | head and skid both hold words; out_valid=1, in_ready=0
module mux_nbit_pipe #(
  parameter int               WIDTH        = 32,
  parameter int               NUM_INPUTS   = 4,
  parameter int               SEL_WIDTH    = 2,
  parameter logic [WIDTH-1:0] DEFAULT_DATA = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] input_data,
  input  logic [SEL_WIDTH-1:0]        select,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            output_data,
  output logic [SEL_WIDTH-1:0]        out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_error,
  input  logic                        err_clr
);

  // Parameter sanity checks. These are resolved at elaboration and add no logic.
  if (SEL_WIDTH != $clog2(NUM_INPUTS)) begin : g_bad_sel_width
    $error("mux_nbit_pipe: SEL_WIDTH must equal ceil(log2(NUM_INPUTS))");
  end
  if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
    $error("mux_nbit_pipe: NUM_INPUTS must be in 2..16");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("mux_nbit_pipe: WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     skid_data;
  logic [SEL_WIDTH-1:0] skid_sel;

  logic [WIDTH-1:0]     cap_data;
  logic                 cap_bad;
  logic                 accept;
  logic                 pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Word selection. An unmatched code leaves the default word and flags it as bad.
  // When NUM_INPUTS is a power of two, every code matches, so cap_bad stays 0.
  always_comb begin
    cap_data = DEFAULT_DATA;
    cap_bad  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (select == k[SEL_WIDTH-1:0]) begin
        cap_data = input_data[k*WIDTH +: WIDTH];
        cap_bad  = 1'b0;
      end
    end
  end

  // Buffer FSM. in_ready and out_valid are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      output_data <= '0;
      out_sel     <= '0;
      skid_data   <= '0;
      skid_sel    <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            output_data <= cap_data;
            out_sel     <= select;
            out_valid   <= 1'b1;
            in_ready    <= 1'b1;
            state       <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            output_data <= cap_data;
            out_sel     <= select;
          end else if (accept) begin
            skid_data   <= cap_data;
            skid_sel    <= select;
            in_ready    <= 1'b0;
            state       <= S_TWO;
          end else if (pop) begin
            out_valid   <= 1'b0;
            state       <= S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            output_data <= skid_data;
            out_sel     <= skid_sel;
            in_ready    <= 1'b1;
            state       <= S_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

  // Sticky select-error flag. A new error on the same edge takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_error <= 1'b0;
    end else if (accept && cap_bad) begin
      sel_error <= 1'b1;
    end else if (err_clr) begin
      sel_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nbit_pipe.sv
module tb_mux_nbit_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-input instance
  logic [4*W-1:0] in4;
  logic [1:0]     sel4;
  logic           v4, ir4, ov4, or4, se4, clr4;
  logic [W-1:0]   od4;
  logic [1:0]     os4;

  // 3-input instance with a non-zero default word
  logic [3*W-1:0] in3;
  logic [1:0]     sel3;
  logic           v3, ir3, ov3, or3, se3, clr3;
  logic [W-1:0]   od3;
  logic [1:0]     os3;

  mux_nbit_pipe #(.WIDTH(W), .NUM_INPUTS(4), .SEL_WIDTH(2), .DEFAULT_DATA(32'h0)) u4 (
    .clk(clk), .rst_n(rst_n), .input_data(in4), .select(sel4), .in_valid(v4),
    .in_ready(ir4), .output_data(od4), .out_sel(os4), .out_valid(ov4),
    .out_ready(or4), .sel_error(se4), .err_clr(clr4));

  mux_nbit_pipe #(.WIDTH(W), .NUM_INPUTS(3), .SEL_WIDTH(2), .DEFAULT_DATA(32'hDEADBEEF)) u3 (
    .clk(clk), .rst_n(rst_n), .input_data(in3), .select(sel3), .in_valid(v3),
    .in_ready(ir3), .output_data(od3), .out_sel(os3), .out_valid(ov3),
    .out_ready(or3), .sel_error(se3), .err_clr(clr3));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model for u4: a FIFO of at most two expected words.
  logic [W-1:0] words[4];
  logic [W-1:0] q_data[$];
  logic [1:0]   q_sel[$];
  logic [W-1:0] m_last_data;
  logic [1:0]   m_last_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_inputs();
    in4 = {words[3], words[2], words[1], words[0]};
    in3 = {words[2], words[1], words[0]};
  endtask

  task automatic model_reset();
    q_data.delete();
    q_sel.delete();
    m_last_data = '0;
    m_last_sel  = '0;
  endtask

  task automatic check4(input string ph);
    chk({ph, " in_ready"},    ir4, (q_data.size() < 2));
    chk({ph, " out_valid"},   ov4, (q_data.size() > 0));
    chk({ph, " output_data"}, od4, m_last_data);
    chk({ph, " out_sel"},     os4, m_last_sel);
    chk({ph, " sel_error4"},  se4, 1'b0);
  endtask

  // One clock: predict the transfer from the model, step the clock, update the model, check u4.
  task automatic cycle(input string ph);
    bit acc, pp;
    logic [W-1:0] w;
    logic [1:0] s;
    acc = v4 && (q_data.size() < 2);
    pp  = (q_data.size() > 0) && or4;
    s   = sel4;
    w   = words[s];
    @(posedge clk);
    #1;
    if (pp) begin
      void'(q_data.pop_front());
      void'(q_sel.pop_front());
    end
    if (acc) begin
      q_data.push_back(w);
      q_sel.push_back(s);
    end
    if (q_data.size() > 0) begin
      m_last_data = q_data[0];
      m_last_sel  = q_sel[0];
    end
    check4(ph);
  endtask

  initial begin
    words[0] = 32'hFFFF0000;
    words[1] = 32'h0000FFFF;
    words[2] = 32'h88888888;
    words[3] = 32'hFEFEFEFE;
    pack_inputs();
    sel4 = '0; v4 = 1'b0; or4 = 1'b0; clr4 = 1'b0;
    sel3 = '0; v3 = 1'b0; or3 = 1'b0; clr3 = 1'b0;
    model_reset();

    // Reset values
    #12;
    chk("rst in_ready", ir4, 1'b1);
    chk("rst out_valid", ov4, 1'b0);
    chk("rst output_data", od4, 32'h0);
    chk("rst out_sel", os4, 2'd0);
    chk("rst sel_error", se4, 1'b0);
    chk("rst sel_error3", se3, 1'b0);
    rst_n = 1'b1;

    // Streaming select 0..3 with out_ready high
    or4 = 1'b1;
    v4  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      cycle("p1");
      chk("p1 stream word", od4, words[i]);
    end
    v4 = 1'b0;
    cycle("p1");
    chk("p1 drained", ov4, 1'b0);

    // Backpressure: three offers with out_ready low
    or4 = 1'b0;
    v4  = 1'b1;
    sel4 = 2'd1; cycle("p2");
    chk("p2 ready after 1st", ir4, 1'b1);
    sel4 = 2'd2; cycle("p2");
    chk("p2 ready after 2nd", ir4, 1'b0);
    sel4 = 2'd3; cycle("p2");
    cycle("p2");
    chk("p2 head held", od4, 32'h0000FFFF);
    or4 = 1'b1;
    cycle("p2");
    chk("p2 pop 2nd", od4, 32'h88888888);
    cycle("p2");
    chk("p2 pop 3rd", od4, 32'hFEFEFEFE);
    v4 = 1'b0;
    cycle("p2");
    chk("p2 empty", ov4, 1'b0);
    cycle("p2");

    // Out-of-range select on the 3-input instance
    or3 = 1'b1;
    v3 = 1'b1; sel3 = 2'd3;
    cycle("p3");
    v3 = 1'b0;
    chk("p3 default data", od3, 32'hDEADBEEF);
    chk("p3 out_sel", os3, 2'd3);
    chk("p3 out_valid", ov3, 1'b1);
    chk("p3 sel_error set", se3, 1'b1);
    cycle("p3");
    cycle("p3");
    chk("p3 sel_error sticky", se3, 1'b1);
    clr3 = 1'b1;
    cycle("p3");
    clr3 = 1'b0;
    chk("p3 sel_error cleared", se3, 1'b0);
    clr3 = 1'b1; v3 = 1'b1; sel3 = 2'd3;
    cycle("p3");
    clr3 = 1'b0; v3 = 1'b0;
    chk("p3 set beats clear", se3, 1'b1);
    clr3 = 1'b1;
    cycle("p3");
    clr3 = 1'b0;
    v3 = 1'b1; sel3 = 2'd2;
    cycle("p3");
    v3 = 1'b0;
    chk("p3 legal data", od3, 32'h88888888);
    chk("p3 legal out_sel", os3, 2'd2);
    chk("p3 legal no error", se3, 1'b0);
    cycle("p3");

    // Async reset while two words are held
    or4 = 1'b0;
    v4 = 1'b1; sel4 = 2'd0; cycle("p4");
    sel4 = 2'd1; cycle("p4");
    v4 = 1'b0;
    chk("p4 full", ir4, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("p4 async out_valid", ov4, 1'b0);
    chk("p4 async in_ready", ir4, 1'b1);
    chk("p4 async output_data", od4, 32'h0);
    chk("p4 async out_sel", os4, 2'd0);
    chk("p4 async sel_error3", se3, 1'b0);
    #2;
    rst_n = 1'b1;
    or4 = 1'b1;
    v4 = 1'b1; sel4 = 2'd2;
    cycle("p4");
    v4 = 1'b0;
    chk("p4 after reset data", od4, 32'h88888888);
    chk("p4 after reset valid", ov4, 1'b1);
    cycle("p4");

    // Random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      if (!(v4 && q_data.size() >= 2)) begin
        v4   = 1'($urandom_range(0, 1));
        sel4 = 2'($urandom_range(0, 3));
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        pack_inputs();
      end
      or4 = ($urandom_range(0, 3) != 0);
      cycle("p5");
    end
    v4  = 1'b0;
    or4 = 1'b1;
    for (int i = 0; i < 3; i++) cycle("p5 drain");
    chk("p5 drained", ov4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nbit_pipe.md
Name: mux_nbit_pipe

Overview:
Parametrised N-input, WIDTH-bit multiplexer with a registered, flow-controlled output. It is the successor to the combinational 2:1 32-bit datapath mux. It selects one of NUM_INPUTS words per accepted transfer and buffers it in a 2-entry skid buffer, so the multicycle datapath can register operand or writeback selection without combinational timing paths. It also flags illegal select codes, and the flag is sticky.

Parameters:
WIDTH, 32, data word width in bits (>=1)
NUM_INPUTS, 4, number of selectable inputs (2..16)
SEL_WIDTH, 2, select width; must equal ceil(log2(NUM_INPUTS)), checked at elaboration
DEFAULT_DATA, 0, word captured when select is out of range

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
input_data  input  NUM_INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
select  input  SEL_WIDTH  input index for the current transfer
in_valid  input  1  upstream offers input_data/select
in_ready  output  1  block can accept; driven from a register
output_data  output  WIDTH  selected word at head of buffer
out_sel  output  SEL_WIDTH  select code that produced output_data
out_valid  output  1  output_data is valid
out_ready  input  1  downstream consumes head
sel_error  output  1  sticky: an accepted transfer had select >= NUM_INPUTS
err_clr  input  1  synchronous clear of sel_error

Behaviour:
- Reset (rst_n low, asynchronous): buffer EMPTY, in_ready=1, out_valid=0, output_data=0, out_sel=0, sel_error=0. Release is synchronised by the standard reset path; first accept can occur on the first rising edge with rst_n high.
- Accept: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Captured word = input_data[select*WIDTH +: WIDTH] if select < NUM_INPUTS, else DEFAULT_DATA. out_sel always captures the raw select code.
- Latency: an accepted word appears on output_data with out_valid=1 in the cycle after the accept edge (1 cycle). There is no combinational path from input_data/select/in_valid to any output, and none from out_ready to in_ready.
- Storage: head register (drives outputs) plus skid register. State machine:
  - EMPTY: accept -> ONE (word to head).
  - ONE: accept & pop -> ONE (new word to head). Accept only -> TWO (word to skid). Pop only -> EMPTY.
  - TWO: in_ready=0, so no accept. Pop -> ONE (skid moves to head). Otherwise hold.
- in_ready = 1 in EMPTY and ONE, 0 in TWO (registered, equal to next-state != TWO).
- Throughput: with out_ready held high, one word per cycle is sustained indefinitely. Order is preserved (FIFO).
- When out_valid=0, output_data and out_sel hold their last values and are not cleared.
- sel_error: set on the edge that accepts an out-of-range select. err_clr=1 clears it on the next edge. If set and clear happen on the same edge, set wins.
- Out-of-range select is not possible when NUM_INPUTS is a power of 2, and sel_error then stays 0.
- Reset mid-operation drops all buffered words. No pop is signalled for them.
- in_valid without in_ready: upstream must hold data stable (standard valid/ready). The block captures nothing.

Test Plan:
1. Reset, then NUM_INPUTS=4, WIDTH=32, inputs {0xFFFF0000, 0x0000FFFF, 0x88888888, 0xFEFEFEFE}, out_ready=1, accept select=0,1,2,3 on consecutive cycles -> output_data shows the same sequence, one cycle later each, with out_valid continuous and in_ready=1 throughout.
2. out_ready=0, accept three words (select 1, 2, 3) -> in_ready drops after the 2nd accept, and the 3rd is not taken until a pop. Then raise out_ready -> outputs 0x0000FFFF, 0x88888888, 0xFEFEFEFE in order, with no loss or duplication.
3. NUM_INPUTS=3, SEL_WIDTH=2, DEFAULT_DATA=0xDEADBEEF, accept select=3 -> output_data=0xDEADBEEF, out_sel=3, sel_error=1 and sticky. Then err_clr=1 for one cycle -> 0. Assert err_clr together with another select=3 accept -> sel_error stays 1.
4. Buffer in state TWO, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, in_ready=1, output_data=0 immediately with no clock edge. After release, accept select=2 -> 0x88888888 one cycle later.
5. Random in_valid/out_ready over 1000 cycles with a scoreboard -> every accepted word emerges once, in order, with the expected mux value. in_ready is never 1 while two words are held.
